cpuc_dual_ram: RTL and testbench
================================

CPUC_DUAL_RAM -- requirements
Module: cpuc_dual_ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set the word address width; DEPTH = 2**ADDR_WIDTH words, so no address is ever out of range.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the word width; it SHALL be a multiple of 8, and NUM_BYTES = DATA_WIDTH/8.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous assertion, active-high.
REQ-005 wr_en  input  1  SHALL be the write request.
REQ-006 wr_addr  input  ADDR_WIDTH  SHALL be the write word address.
REQ-007 wr_data  input  DATA_WIDTH  SHALL be the write data.
REQ-008 wr_be  input  NUM_BYTES  SHALL be the per-byte write enables; bit i selects wr_data[8i+7:8i].
REQ-009 rd_en  input  1  SHALL be the read request.
REQ-010 rd_addr  input  ADDR_WIDTH  SHALL be the read word address.
REQ-011 rd_data  output  DATA_WIDTH  SHALL carry the registered read data.
REQ-012 rd_valid  output  1  SHALL pulse high for one cycle when rd_data holds a new read result.
REQ-013 ready  output  1  SHALL be high when requests are accepted.

Function
REQ-014 Writes: with ready=1 and wr_en=1 at edge N, mem[wr_addr] SHALL update at edge N, changing only the bytes whose wr_be bit is set.
REQ-015 Reads: with ready=1 and rd_en=1 at edge N, rd_data and rd_valid=1 SHALL be registered at edge N and visible in the cycle after edge N (1-cycle latency).
REQ-016 Without an accepted read at edge N, rd_valid SHALL be 0 after edge N, and rd_data SHALL hold its previous value.
REQ-017 The read port and the write port SHALL operate independently in the same cycle.
REQ-018 Collision: when a read and a write are accepted to the same address at the same edge, the read SHALL be write-first:
- bytes with wr_be set SHALL return the new wr_data bytes;
- all other bytes SHALL return the old memory bytes.
REQ-019 State machine: states RAM_CLEAR and RAM_READY; ready = (state == RAM_READY).
REQ-020 In RAM_CLEAR, on each edge the block SHALL write 0 to mem[clr_cnt] and increment clr_cnt (ADDR_WIDTH bits).
REQ-021 When the edge with clr_cnt == DEPTH-1 occurs, the state SHALL become RAM_READY. ready therefore rises exactly DEPTH edges after reset release.
REQ-022 While ready=0, wr_en and rd_en SHALL be ignored: no memory change and rd_valid=0.
REQ-023 RAM_READY SHALL be terminal until the next reset.

Reset
REQ-024 While rst=1:
- rd_data = 0 and rd_valid = 0;
- clr_cnt = 0;
- the state SHALL take its reset value per REQ-027/REQ-028.
REQ-025 Memory contents SHALL not be reset directly; only the clear sweep (REQ-020) initialises them.
REQ-026 Reset asserted mid-sweep or mid-operation SHALL abort immediately; the sweep SHALL restart from address 0 after release.

Configuration
REQ-027 With CPUC_RAM_INIT_CLR_EN defined:
- the state SHALL reset to RAM_CLEAR, so ready = 0 during reset;
- the sweep SHALL run as per REQ-020 and REQ-021.
REQ-028 Without CPUC_RAM_INIT_CLR_EN:
- the clear logic and clr_cnt SHALL be compiled out;
- the state SHALL reset to RAM_READY, so ready = 1 from reset;
- memory contents after reset SHALL be undefined.

Structure
REQ-029 cpuc_package SHALL hold:
- typedef enum t_ram_state {RAM_CLEAR, RAM_READY};
- constant CPUC_RAM_ADDR_W = 10.
REQ-030 Flops SHALL use the shared CPUC DFF macros (reset and enable variants).
REQ-031 Byte-merge logic (old word, new word, byte enables -> merged word) SHALL be the sub-module cpuc_ram_be_merge, used by both the write path and the collision bypass.

Verification (ADDR_WIDTH=4, DATA_WIDTH=32, macro defined)
REQ-032 Release rst, then count edges -> ready rises after exactly 16 edges; reads of addresses 0..15 -> rd_data = 0x00000000, with one rd_valid pulse each.
REQ-033 Write 0xDEADBEEF to address 3 with be=4'hF, then read address 3 -> rd_data = 0xDEADBEEF and rd_valid=1 for one cycle, one cycle after rd_en.
REQ-034 Write 0x11223344 to address 3 with be=4'b0101 over 0xDEADBEEF -> a read returns 0xDE22BE44.
REQ-035 Same-edge write of 0xCAFEF00D (be=4'hF) and read, both at address 5 (old value 0) -> rd_data = 0xCAFEF00D.
REQ-036 Assert rst at sweep edge 8, then release:
- ready SHALL stay 0 for 16 more edges;
- a write of 0x12345678 to address 2 issued while ready=0 -> a later read of address 2 returns 0.
REQ-037 Macro undefined -> ready = 1 in the first cycle after reset release; write/read of address 0 works immediately.

Source files
------------

// File: rtl/cpuc_package.sv
// cpuc_package: shared RAM state type, address-width constant and the
// CPUC DFF macros (reset and enable variants) used by the RAM slice.
// The macros expect 'clk' and 'rst' to be in scope at the point of use.
`ifndef CPUC_DFF_MACROS
`define CPUC_DFF_MACROS
`define CPUC_DFF_R(q, d, rv) \
  always_ff @(posedge clk or posedge rst) begin \
    if (rst) q <= (rv); \
    else     q <= (d); \
  end
`define CPUC_DFF_EN(q, d, en) \
  always_ff @(posedge clk) begin \
    if (en) q <= (d); \
  end
`endif

package cpuc_package;

  typedef enum logic {
    RAM_CLEAR = 1'b0,
    RAM_READY = 1'b1
  } t_ram_state;

  localparam int CPUC_RAM_ADDR_W = 10;

endpackage

// File: rtl/cpuc_ram_be_merge.sv
// cpuc_ram_be_merge: combines an old word with a new word under per-byte
// enables; enabled bytes come from new_word, the rest from old_word.
module cpuc_ram_be_merge
  import cpuc_package::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_word,
  input  logic [DATA_WIDTH-1:0]   new_word,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   merged
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  // Byte-wise select between the old and the new word
  always_comb begin
    merged = old_word;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/cpuc_dual_ram.sv
// cpuc_dual_ram: simple dual-port RAM (one write port with byte enables,
// one registered read port) with write-first collision bypass.
// Optional feature macro: CPUC_RAM_INIT_CLR_EN -- when defined, the RAM
// sweeps zeros into every word after reset and only then raises ready.
// Without it, ready is high from reset and contents start undefined.
module cpuc_dual_ram
  import cpuc_package::*;
#(
  parameter int ADDR_WIDTH = CPUC_RAM_ADDR_W,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  t_ram_state              state_q, state_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_waddr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   wr_old;
  logic [DATA_WIDTH-1:0]   wr_merged;
  logic                    acc_wr, acc_rd, collide;

  assign ready   = (state_q == RAM_READY);
  assign acc_wr  = ready & wr_en;
  assign acc_rd  = ready & rd_en;
  assign collide = acc_wr & acc_rd & (wr_addr == rd_addr);
  assign wr_old  = mem_q[wr_addr];

  // One merge serves both the memory write and the collision bypass: on a
  // collision the read address equals the write address, so the merged
  // word is exactly what the read must return.
  cpuc_ram_be_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_be_merge (
    .old_word (wr_old),
    .new_word (wr_data),
    .be       (wr_be),
    .merged   (wr_merged)
  );

`ifdef CPUC_RAM_INIT_CLR_EN
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  // Clear sweep: step through every address, then settle in RAM_READY
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == RAM_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (&clr_cnt_q) state_d = RAM_READY;
    end
  end

  // State register; reset restarts the sweep
  `CPUC_DFF_R(state_q, state_d, RAM_CLEAR)

  // Sweep address counter
  `CPUC_DFF_R(clr_cnt_q, clr_cnt_d, '0)
`else
  // No sweep: RAM_READY is both the reset and the only reachable state
  always_comb begin
    state_d = state_q;
  end

  // State register
  `CPUC_DFF_R(state_q, state_d, RAM_READY)
`endif

  // Memory write port: user write when ready, zero-fill during the sweep
  always_comb begin
    mem_we_d    = acc_wr;
    mem_waddr_d = wr_addr;
    mem_wdata_d = wr_merged;
`ifdef CPUC_RAM_INIT_CLR_EN
    if (state_q == RAM_CLEAR) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = clr_cnt_q;
      mem_wdata_d = '0;
    end
`endif
  end

  // Memory array; contents are never reset directly
  `CPUC_DFF_EN(mem_q[mem_waddr_d], mem_wdata_d, mem_we_d)

  // Read port: new data only on an accepted read, otherwise hold
  always_comb begin
    rd_valid_d = acc_rd;
    rd_data_d  = rd_data_q;
    if (acc_rd) rd_data_d = collide ? wr_merged : mem_q[rd_addr];
  end

  // Registered read data
  `CPUC_DFF_R(rd_data_q, rd_data_d, '0)

  // One-cycle read valid pulse
  `CPUC_DFF_R(rd_valid_q, rd_valid_d, 1'b0)

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_cpuc_dual_ram.sv
// tb_cpuc_dual_ram: directed bench for cpuc_dual_ram (ADDR_WIDTH=4,
// DATA_WIDTH=32). Covers whichever build CPUC_RAM_INIT_CLR_EN selects.
module tb_cpuc_dual_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        ready;

  int tests = 0;
  int fails = 0;
  int n;

  always #5 clk = ~clk;

  cpuc_dual_ram #(
    .ADDR_WIDTH (4),
    .DATA_WIDTH (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .ready    (ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    wr_be   = '0;
    rd_en   = 1'b0;
    rd_addr = '0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    idle();
  endtask

  // Read with 1-cycle latency, then confirm the pulse drops and data holds
  task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
    rd_en = 1'b1; rd_addr = a;
    tick();
    idle();
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_data"}, rd_data, exp);
    tick();
    check({tag, "_vld_drop"}, 32'(rd_valid), 32'd0);
    check({tag, "_hold"}, rd_data, exp);
  endtask

  // Hold a write and a read to address 2 while counting edges to ready
  task automatic sweep_and_count(output int cnt);
    cnt = 0;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h12345678; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd2;
    while (cnt < 40) begin
      tick();
      cnt++;
      if (ready) break;
      check("sweep_rd_valid", 32'(rd_valid), 32'd0);
    end
    idle();
  endtask

  task automatic func_tests();
    do_write(4'd0, 32'hA5A55A5A, 4'hF);
    do_read(4'd0, 32'hA5A55A5A, "rd_a0");
    do_write(4'd3, 32'hDEADBEEF, 4'hF);
    do_read(4'd3, 32'hDEADBEEF, "rd_full");
    do_write(4'd3, 32'h11223344, 4'b0101);
    do_read(4'd3, 32'hDE22BE44, "rd_partial");
    // Full-word collision, old value 0
    do_write(4'd5, 32'h00000000, 4'hF);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    idle();
    check("coll_full_valid", 32'(rd_valid), 32'd1);
    check("coll_full_data", rd_data, 32'hCAFEF00D);
    // Partial collision: only byte 3 comes from the write
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h11111111; wr_be = 4'b1000;
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    idle();
    check("coll_part_data", rd_data, 32'h11FEF00D);
    do_read(4'd5, 32'h11FEF00D, "rd_after_coll");
    // Independent ports, different addresses
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h77777777; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    idle();
    check("indep_data", rd_data, 32'hDE22BE44);
    do_read(4'd7, 32'h77777777, "rd_indep_wr");
    do_write(4'd7, 32'hFFFFFFFF, 4'h0);
    do_read(4'd7, 32'h77777777, "rd_be_zero");
    // Asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_data", rd_data, 32'h0);
    check("async_rst_valid", 32'(rd_valid), 32'd0);
`ifdef CPUC_RAM_INIT_CLR_EN
    check("async_rst_ready", 32'(ready), 32'd0);
`else
    check("async_rst_ready", 32'(ready), 32'd1);
`endif
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
`ifdef CPUC_RAM_INIT_CLR_EN
    check("rst_ready", 32'(ready), 32'd0);
    rst = 1'b0;
    sweep_and_count(n);
    check("sweep_edges", 32'(n), 32'd16);
    for (int a = 0; a < 16; a++) do_read(4'(a), 32'h0, "clr_read");
    func_tests();
    // Abort the sweep at edge 8 and confirm a full restart
    for (int i = 0; i < 8; i++) tick();
    check("mid_sweep_ready", 32'(ready), 32'd0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    sweep_and_count(n);
    check("resweep_edges", 32'(n), 32'd16);
    do_read(4'd2, 32'h0, "ignored_wr");
`else
    check("rst_ready", 32'(ready), 32'd1);
    rst = 1'b0;
    check("rel_ready", 32'(ready), 32'd1);
    func_tests();
    check("rel2_ready", 32'(ready), 32'd1);
    do_write(4'd0, 32'h0BADF00D, 4'hF);
    do_read(4'd0, 32'h0BADF00D, "post_rst_a0");
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
